// File: rtl/ctrl_alu_pkg.sv
// Shared constants for the decode/execute stage: opcodes, funct codes,
// aluOp encodings and the 4-bit ALU control codes.
package ctrl_alu_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // aluOp encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

endpackage

// File: rtl/ctrl_alu_stage_alu_core.sv
// alu_core: purely combinational ALU. Add/sub wrap modulo 2^DATA_W,
// slt is signed, unknown codes produce 0 (and therefore zero=1).
module alu_core
  import ctrl_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_ctr,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Select the operation by control code
  always_comb begin
    result = '0;
    case (alu_ctr)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ctrl_alu_stage.sv
// ctrl_alu_stage: opcode decode, ALU control decode, ALU execute and an
// EX/MEM-style output register. Optional macro CTR_JUMP_EN enables decode
// of the jump opcode; without it that opcode behaves as any illegal one.
module ctrl_alu_stage
  import ctrl_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        op_code,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm_ext,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [1:0]        alu_op,
  output logic [3:0]        alu_ctr,
  output logic [DATA_W-1:0] alu_res_q,
  output logic              zero_q,
  output logic              reg_write_q,
  output logic              mem_to_reg_q,
  output logic              branch_q,
  output logic              mem_read_q,
  output logic              mem_write_q
);

  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_zero;
  logic [DATA_W-1:0] alu_res_d;
  logic              zero_d, reg_write_d, mem_to_reg_d, branch_d;
  logic              mem_read_d, mem_write_d;

  // Main control decode from opcode; illegal opcodes leave everything 0
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALUOP_ADD;
    case (op_code)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = ALUOP_SUB;
      end
`ifdef CTR_JUMP_EN
      OP_J: jump = 1'b1;
`endif
      default: ;
    endcase
  end

  // ALU control from aluOp, consulting funct only for R-type
  always_comb begin
    alu_ctr = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctr = ALU_ADD;
      ALUOP_SUB: alu_ctr = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctr = ALU_ADD;
          FN_SUB:  alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_NOR:  alu_ctr = ALU_NOR;
          default: alu_ctr = ALU_BAD;
        endcase
      end
      default: alu_ctr = ALU_ADD;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : read_data2;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a       (read_data1),
    .b       (alu_b),
    .alu_ctr (alu_ctr),
    .result  (alu_res),
    .zero    (alu_zero)
  );

  // Next-state for the output register: advance on enable, else hold
  always_comb begin
    alu_res_d    = alu_res_q;
    zero_d       = zero_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    branch_d     = branch_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (enable) begin
      alu_res_d    = alu_res;
      zero_d       = alu_zero;
      reg_write_d  = reg_write;
      mem_to_reg_d = mem_to_reg;
      branch_d     = branch;
      mem_read_d   = mem_read;
      mem_write_d  = mem_write;
    end
  end

  // EX/MEM register, cleared asynchronously by reset
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      alu_res_q    <= '0;
      zero_q       <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      alu_res_q    <= alu_res_d;
      zero_q       <= zero_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_ctrl_alu_stage.sv
// Directed bench for ctrl_alu_stage with hand-computed expectations.
// Honours CTR_JUMP_EN for the jump-opcode expectation.
module tb_ctrl_alu_stage;

  localparam int DATA_W = 32;

  logic              clock_in = 1'b0;
  logic              reset, enable;
  logic [5:0]        op_code, funct;
  logic [DATA_W-1:0] read_data1, read_data2, imm_ext;
  logic              reg_dst, alu_src, mem_to_reg, reg_write, mem_read;
  logic              mem_write, branch, jump;
  logic [1:0]        alu_op;
  logic [3:0]        alu_ctr;
  logic [DATA_W-1:0] alu_res_q;
  logic              zero_q, reg_write_q, mem_to_reg_q, branch_q;
  logic              mem_read_q, mem_write_q;

  int checks = 0;
  int failures = 0;

  ctrl_alu_stage #(.DATA_W(DATA_W)) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .enable       (enable),
    .op_code      (op_code),
    .funct        (funct),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .imm_ext      (imm_ext),
    .reg_dst      (reg_dst),
    .alu_src      (alu_src),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .jump         (jump),
    .alu_op       (alu_op),
    .alu_ctr      (alu_ctr),
    .alu_res_q    (alu_res_q),
    .zero_q       (zero_q),
    .reg_write_q  (reg_write_q),
    .mem_to_reg_q (mem_to_reg_q),
    .branch_q     (branch_q),
    .mem_read_q   (mem_read_q),
    .mem_write_q  (mem_write_q)
  );

  always #5 clock_in = ~clock_in;

  // Packed views: controls {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,
  // mem_write,branch,jump,alu_op[1:0]}; registered flags {reg_write_q,
  // mem_to_reg_q,branch_q,mem_read_q,mem_write_q,zero_q}
  logic [9:0] ctl;
  logic [5:0] qf;
  assign ctl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                mem_write, branch, jump, alu_op};
  assign qf  = {reg_write_q, mem_to_reg_q, branch_q, mem_read_q,
                mem_write_q, zero_q};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm);
    op_code = op; funct = fn; read_data1 = a; read_data2 = b; imm_ext = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // R-type funct table: funct, A, B, expected alu_ctr, expected result
  logic [5:0]  fn_tab  [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [31:0] a_tab   [5] = '{32'd3, 32'hF0F0_00FF, 32'hF000_0000, 32'h0000_FFFF, 32'd1};
  logic [31:0] b_tab   [5] = '{32'd5, 32'h0FF0_0F0F, 32'h0000_000F, 32'hFF00_0000, 32'hFFFF_FFFF};
  logic [3:0]  ctr_tab [5] = '{4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  logic [31:0] res_tab [5] = '{32'hFFFF_FFFE, 32'h00F0_000F, 32'hF000_000F, 32'h00FF_0000, 32'd0};

  initial begin
    reset = 1'b1; enable = 1'b0;
    drive(6'b000000, 6'b100000, 32'd0, 32'd0, 32'd0);
    #12;
    chk("reset_res", alu_res_q, 32'd0);
    chk("reset_flags", {26'd0, qf}, 32'd0);

    // Release between edges, then R-type add 5+7
    @(negedge clock_in);
    reset = 1'b0; enable = 1'b1;
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
    chk("radd_ctl", {22'd0, ctl}, {22'd0, 10'b1001000010});
    chk("radd_ctr", {28'd0, alu_ctr}, 32'd2);
    tick();
    chk("radd_res", alu_res_q, 32'd12);
    chk("radd_flags", {26'd0, qf}, {26'd0, 6'b100000});

    // beq with equal operands
    drive(6'b000100, 6'b000000, 32'h1234, 32'h1234, 32'h0);
    chk("beq_ctl", {22'd0, ctl}, {22'd0, 10'b0000001001});
    chk("beq_ctr", {28'd0, alu_ctr}, 32'd6);
    tick();
    chk("beq_res", alu_res_q, 32'd0);
    chk("beq_flags", {26'd0, qf}, {26'd0, 6'b001001});

    // lw address calc uses immediate, not read_data2
    drive(6'b100011, 6'b000000, 32'h100, 32'hDEAD, 32'hFFFF_FFFC);
    chk("lw_ctl", {22'd0, ctl}, {22'd0, 10'b0111100000});
    tick();
    chk("lw_res", alu_res_q, 32'hFC);
    chk("lw_flags", {26'd0, qf}, {26'd0, 6'b110100});

    // sw
    drive(6'b101011, 6'b000000, 32'h200, 32'h5555, 32'h8);
    chk("sw_ctl", {22'd0, ctl}, {22'd0, 10'b0100010000});
    tick();
    chk("sw_res", alu_res_q, 32'h208);
    chk("sw_flags", {26'd0, qf}, {26'd0, 6'b000010});

    // slt signed: -1 < 1
    drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("slt_ctr", {28'd0, alu_ctr}, 32'd7);
    tick();
    chk("slt_neg_res", alu_res_q, 32'd1);
    chk("slt_neg_zero", {31'd0, zero_q}, 32'd0);

    // add wraps into the sign bit
    drive(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'd0);
    tick();
    chk("add_wrap", alu_res_q, 32'h8000_0000);

    // Remaining R-type functions
    for (int i = 0; i < 5; i++) begin
      drive(6'b000000, fn_tab[i], a_tab[i], b_tab[i], 32'd0);
      chk($sformatf("rt%0d_ctr", i), {28'd0, alu_ctr}, {28'd0, ctr_tab[i]});
      tick();
      chk($sformatf("rt%0d_res", i), alu_res_q, res_tab[i]);
      chk($sformatf("rt%0d_zero", i), {31'd0, zero_q}, {31'd0, res_tab[i] == 32'd0});
    end

    // Load a known value then pause and change inputs
    drive(6'b000000, 6'b100000, 32'd40, 32'd2, 32'd0);
    tick();
    chk("pre_pause_res", alu_res_q, 32'd42);
    enable = 1'b0;
    drive(6'b100011, 6'b000000, 32'd1, 32'd1, 32'd1);
    tick();
    tick();
    chk("pause_res", alu_res_q, 32'd42);
    chk("pause_flags", {26'd0, qf}, {26'd0, 6'b100000});

    // Mid-cycle reset clears immediately and holds while high
    enable = 1'b1;
    tick();
    chk("pre_rst_res", alu_res_q, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_res", alu_res_q, 32'd0);
    chk("midrst_flags", {26'd0, qf}, 32'd0);
    tick();
    chk("rst_hold_res", alu_res_q, 32'd0);
    @(negedge clock_in);
    reset = 1'b0;

    // Illegal opcode
    drive(6'b111111, 6'b100000, 32'd1, 32'd2, 32'd3);
    chk("illop_ctl", {22'd0, ctl}, 32'd0);
    chk("illop_ctr", {28'd0, alu_ctr}, 32'd2);

    // Illegal funct on R-type
    drive(6'b000000, 6'b000000, 32'd9, 32'd9, 32'd0);
    chk("illfn_ctr", {28'd0, alu_ctr}, 32'hF);
    tick();
    chk("illfn_res", alu_res_q, 32'd0);
    chk("illfn_zero", {31'd0, zero_q}, 32'd1);

    // Jump opcode
    drive(6'b000010, 6'b000000, 32'd0, 32'd0, 32'd0);
`ifdef CTR_JUMP_EN
    chk("jump_ctl", {22'd0, ctl}, {22'd0, 10'b0000000100});
`else
    chk("jump_ctl", {22'd0, ctl}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_alu_stage.md
Name: ctrl_alu_stage

Overview:
- Single-cycle-issue decode/execute unit for the 5-stage MIPS pipeline.
- Combinationally decodes the opcode into the main control bundle and decodes aluOp+funct into a 4-bit ALU control.
- Performs the ALU operation and registers the result, zero flag and forwarded control bits into an EX/MEM-style output register.
- Sits between the ID/EX pipeline register and the data memory.

Parameters:
- DATA_W, 32, ALU operand/result width.

Ports:
- clock_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registered outputs.
- enable  in  1  pipeline advance; 0 holds all registered outputs (pause).
- op_code  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- read_data1  in  DATA_W  ALU operand A.
- read_data2  in  DATA_W  register operand B.
- imm_ext  in  DATA_W  sign-extended immediate.
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  out  1 each  combinational decode of op_code.
- alu_op  out  2  combinational decode of op_code.
- alu_ctr  out  4  combinational ALU control.
- alu_res_q  out  DATA_W  registered ALU result.
- zero_q  out  1  registered zero flag.
- reg_write_q, mem_to_reg_q, branch_q, mem_read_q, mem_write_q  out  1 each  registered control copies.

Behaviour:
- Opcode decode, listed as regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, aluOp:
  - 000000 R-type: 1,0,0,1,0,0,0,10.
  - 100011 lw: 0,1,1,1,1,0,0,00.
  - 101011 sw: 0,1,0,0,0,1,0,00.
  - 000100 beq: 0,0,0,0,0,0,1,01.
  - Any other opcode: all outputs 0, aluOp 00, jump 0.
- ALU control decode:
  - aluOp 00 → 0010 (add).
  - aluOp 01 → 0110 (sub).
  - aluOp 11 → 0010.
  - aluOp 10 uses funct: 100000→0010 add; 100010→0110 sub; 100100→0000 and; 100101→0001 or; 101010→0111 slt; 100111→1100 nor; any other funct→1111.
- ALU:
  - Operand B = alu_src ? imm_ext : read_data2.
  - Results by code: 0000 A&B; 0001 A|B; 0010 A+B, wrap modulo 2^DATA_W, no overflow trap; 0110 A−B, wrap; 0111 signed A<B → 1 else 0; 1100 ~(A|B); 1111 and any other code → 0.
  - zero = (result == 0), so the 1111 code yields zero=1.
- Registers:
  - Capture on rising clock_in when enable=1.
  - Latency one cycle from inputs to *_q.
  - enable=0 holds values.
  - reset asserted at any time, including mid-stream, forces all *_q to 0 immediately and holds them there while high.
  - First capture occurs on the first rising edge after reset deasserts with enable=1.
- All non-_q outputs are purely combinational; no reset dependence.

Optional Feature:
- Macro CTR_JUMP_EN.
- Defined: opcode 000010 decodes to jump=1, all other controls 0, aluOp 00.
- Undefined: opcode 000010 falls into the default case, all controls 0 and jump tied to 0.
- The jump output port exists in both builds.

Decomposition:
- Shared package ctrl_alu_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - funct constants: add, sub, and, or, slt, nor.
  - aluOp constants: 00, 01, 10.
  - 4-bit ALU control codes.
- One sub-module is natural: alu_core, purely combinational (A, B, alu_ctr → result, zero).
- Opcode and aluCtr decode stay inline in the top as case statements.

Test Plan:
- R-type add: op 000000, funct 100000, A=5, B=7, enable=1, one clock → alu_res_q=12, zero_q=0, reg_write_q=1, reg_dst=1.
- beq equal: op 000100, A=B=0x1234 → alu_ctr=0110; after clock zero_q=1, branch_q=1, reg_write_q=0.
- lw address: op 100011, A=0x100, imm_ext=0xFFFFFFFC → alu_src=1; alu_res_q=0xFC, mem_read_q=1, mem_to_reg_q=1.
- slt signed and wrap:
  - A=0xFFFFFFFF, B=1, funct 101010 → result 1.
  - A=0x7FFFFFFF, B=1, funct 100000 → result 0x80000000.
- Pause and reset:
  - Load a result, set enable=0, change inputs → *_q hold.
  - Assert reset between clock edges → all *_q become 0 before the next edge.
- Illegal codes:
  - op 111111 → all controls 0.
  - funct 000000 with op 000000 → alu_ctr=1111, result 0, zero 1.
  - op 000010 → jump=1 only with CTR_JUMP_EN defined.
